// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port 256x16 RAM.
// Port 0 is the CPU, port 1 the debug/program-loader engine. Each granted
// request becomes exactly one RAM access. Read data comes back with an
// rvalid pulse the cycle after the grant. Addresses with any bit set above
// MEM_AW (the I/O space) never reach the RAM and are answered with err.
// Optional build macro: ARB_LOCK_EN adds lock0/lock1 for atomic bursts.
module mem_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned MEM_AW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
`ifdef ARB_LOCK_EN
  input  logic              lock0,
  input  logic              lock1,
`endif
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              err0,
  output logic              err1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  logic [0:0]        state_q;
  logic              owner_q;
  logic              last_owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  // Response bookkeeping for the cycle after ISSUE
  logic              resp_rd_q;
  logic              resp_err_q;
  logic              resp_owner_q;

  logic              elig0, elig1;
  logic              any_req;
  logic              pick;
  logic              in_range;
  logic              issue;

`ifdef ARB_LOCK_EN
  logic              lock_act_q;
  logic              lock_port_q;
  logic              pick_lock;
`endif

  assign in_range = (addr_q[ADDR_W-1:MEM_AW] == '0);
  // Outputs are forced to their reset values while reset is high, so an
  // access caught in ISSUE is dropped from the very first reset cycle.
  assign issue    = (state_q == ISSUE) && !reset;

  // Eligibility and round-robin winner selection
  always_comb begin
    elig0 = req0;
    elig1 = req1;
`ifdef ARB_LOCK_EN
    if (lock_act_q) begin
      elig0 = req0 && (lock_port_q == 1'b0);
      elig1 = req1 && (lock_port_q == 1'b1);
    end
`endif
    any_req = elig0 || elig1;
    // Port 1 wins when alone or when port 0 had the previous grant
    pick    = elig1 && (!elig0 || (last_owner_q == 1'b0));
  end

`ifdef ARB_LOCK_EN
  assign pick_lock = pick ? lock1 : lock0;
`endif

  // State, request latch and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_rd_q    <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_owner_q <= 1'b0;
`ifdef ARB_LOCK_EN
      lock_act_q   <= 1'b0;
      lock_port_q  <= 1'b0;
`endif
    end else begin
      resp_rd_q    <= issue && !we_q;
      resp_err_q   <= issue && !in_range;
      resp_owner_q <= owner_q;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q      <= ISSUE;
            owner_q      <= pick;
            last_owner_q <= pick;
            we_q         <= pick ? we1 : we0;
            addr_q       <= pick ? addr1 : addr0;
            wdata_q      <= pick ? wdata1 : wdata0;
`ifdef ARB_LOCK_EN
            lock_act_q   <= pick_lock;
            lock_port_q  <= pick;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Grant and RAM strobes, valid only in ISSUE
  always_comb begin
    gnt0     = issue && (owner_q == 1'b0);
    gnt1     = issue && (owner_q == 1'b1);
    mem_en   = issue && in_range;
    mem_we   = issue && in_range && we_q;
    mem_addr = issue ? addr_q[MEM_AW-1:0] : '0;
    mem_din  = issue ? wdata_q : '0;
  end

  // Response pulses and shared read data
  always_comb begin
    rvalid0 = !reset && resp_rd_q && (resp_owner_q == 1'b0);
    rvalid1 = !reset && resp_rd_q && (resp_owner_q == 1'b1);
    err0    = !reset && resp_err_q && (resp_owner_q == 1'b0);
    err1    = !reset && resp_err_q && (resp_owner_q == 1'b1);
    rdata   = (!reset && resp_rd_q && !resp_err_q) ? mem_dout : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a behavioural synchronous RAM.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [8:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
`ifdef ARB_LOCK_EN
  logic        lock0, lock1;
`endif
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [15:0] rdata;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;

  logic [15:0] ram [256];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .req0     (req0),
    .req1     (req1),
    .we0      (we0),
    .we1      (we1),
    .addr0    (addr0),
    .addr1    (addr1),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
`ifdef ARB_LOCK_EN
    .lock0    (lock0),
    .lock1    (lock1),
`endif
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .rvalid0  (rvalid0),
    .rvalid1  (rvalid1),
    .rdata    (rdata),
    .err0     (err0),
    .err1     (err1),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  // RAM model; reset preloads the known test words
  always @(posedge clk) begin
    if (reset) begin
      ram[8'h05] <= 16'hD401;
      ram[8'h40] <= 16'h1234;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      mem_dout <= ram[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0 = 1'b1; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 9'h005; addr1 = 9'h000; wdata0 = '0; wdata1 = '0;
`ifdef ARB_LOCK_EN
    lock0 = 1'b0; lock1 = 1'b0;
`endif
    tick(); tick(); tick();
    n_cmp++;
    if ({gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_en, mem_we} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 00000000",
               {gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_en, mem_we});
    end
    n_cmp++;
    if ({mem_addr, mem_din, rdata} !== 40'h0) begin
      n_err++;
      $display("FAIL reset_data: got %h want 0", {mem_addr, mem_din, rdata});
    end
    req0 = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_read();
    req0 = 1'b1; we0 = 1'b0; addr0 = 9'h005;
    tick();
    n_cmp++;
    if ({gnt0, gnt1, mem_en, mem_we} !== 4'b1010) begin
      n_err++; $display("FAIL read_issue: got %b want 1010", {gnt0, gnt1, mem_en, mem_we});
    end
    n_cmp++;
    if (mem_addr !== 8'h05) begin
      n_err++; $display("FAIL read_addr: got %h want 05", mem_addr);
    end
    req0 = 1'b0;
    tick();
    n_cmp++;
    if ({rvalid0, rvalid1, err0, err1, gnt1} !== 5'b10000) begin
      n_err++; $display("FAIL read_resp: got %b want 10000", {rvalid0, rvalid1, err0, err1, gnt1});
    end
    n_cmp++;
    if (rdata !== 16'hD401) begin
      n_err++; $display("FAIL read_data: got %h want d401", rdata);
    end
    tick();
  endtask

  task automatic test_write_read();
    req1 = 1'b1; we1 = 1'b1; addr1 = 9'h014; wdata1 = 16'h0352;
    tick();
    n_cmp++;
    if ({gnt0, gnt1, mem_en, mem_we} !== 4'b0111) begin
      n_err++; $display("FAIL wr_issue: got %b want 0111", {gnt0, gnt1, mem_en, mem_we});
    end
    n_cmp++;
    if ({mem_addr, mem_din} !== {8'h14, 16'h0352}) begin
      n_err++; $display("FAIL wr_bus: got %h want 140352", {mem_addr, mem_din});
    end
    req1 = 1'b0;
    tick();
    n_cmp++;
    if ({rvalid0, rvalid1, err0, err1, mem_en, mem_we} !== 6'b0) begin
      n_err++;
      $display("FAIL wr_noresp: got %b want 000000", {rvalid0, rvalid1, err0, err1, mem_en, mem_we});
    end
    req1 = 1'b1; we1 = 1'b0;
    tick();
    n_cmp++;
    if ({gnt0, gnt1, mem_en, mem_we} !== 4'b0110) begin
      n_err++; $display("FAIL rd1_issue: got %b want 0110", {gnt0, gnt1, mem_en, mem_we});
    end
    req1 = 1'b0;
    tick();
    n_cmp++;
    if ({rvalid0, rvalid1, err0, err1, rdata} !== {4'b0100, 16'h0352}) begin
      n_err++;
      $display("FAIL rd1_resp: got %b/%h want 0100/0352", {rvalid0, rvalid1, err0, err1}, rdata);
    end
    tick();
  endtask

  task automatic test_contention();
    logic exp_own;
    reset = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 9'h005;
    req1 = 1'b1; we1 = 1'b0; addr1 = 9'h014;
    tick();
    reset = 1'b0;
    exp_own = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({gnt0, gnt1} !== {~exp_own, exp_own}) begin
        n_err++; $display("FAIL cont_gnt%0d: got %b want %b", i, {gnt0, gnt1}, {~exp_own, exp_own});
      end
      if (i == 3) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      tick();
      n_cmp++;
      if ({gnt0, gnt1, rvalid0, rvalid1, rdata} !==
          {2'b00, ~exp_own, exp_own, (exp_own ? 16'h0352 : 16'hD401)}) begin
        n_err++;
        $display("FAIL cont_resp%0d: got %b/%h own %b", i, {gnt0, gnt1, rvalid0, rvalid1}, rdata,
                 exp_own);
      end
      exp_own = ~exp_own;
    end
    tick();
  endtask

  task automatic test_out_of_range();
    req0 = 1'b1; we0 = 1'b0; addr0 = 9'h100;
    tick();
    n_cmp++;
    if ({gnt0, gnt1, mem_en, mem_we} !== 4'b1000) begin
      n_err++; $display("FAIL oor_rd_issue: got %b want 1000", {gnt0, gnt1, mem_en, mem_we});
    end
    req0 = 1'b0;
    tick();
    n_cmp++;
    if ({rvalid0, err0, rvalid1, err1, rdata} !== {4'b1100, 16'h0}) begin
      n_err++;
      $display("FAIL oor_rd_resp: got %b/%h want 1100/0000", {rvalid0, err0, rvalid1, err1}, rdata);
    end
    req0 = 1'b1; we0 = 1'b1; addr0 = 9'h140; wdata0 = 16'hFFFF;
    tick();
    n_cmp++;
    if ({gnt0, gnt1, mem_en, mem_we} !== 4'b1000) begin
      n_err++; $display("FAIL oor_wr_issue: got %b want 1000", {gnt0, gnt1, mem_en, mem_we});
    end
    req0 = 1'b0;
    tick();
    n_cmp++;
    if ({rvalid0, err0, rvalid1, err1} !== 4'b0100) begin
      n_err++; $display("FAIL oor_wr_resp: got %b want 0100", {rvalid0, err0, rvalid1, err1});
    end
    // The alias 0x040 must still hold its preloaded word
    req0 = 1'b1; we0 = 1'b0; addr0 = 9'h040;
    tick();
    req0 = 1'b0;
    tick();
    n_cmp++;
    if ({rvalid0, err0, rdata} !== {2'b10, 16'h1234}) begin
      n_err++; $display("FAIL oor_ram_kept: got %b/%h want 10/1234", {rvalid0, err0}, rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    req0 = 1'b1; we0 = 1'b0; addr0 = 9'h005;
    tick();
    reset = 1'b1; req0 = 1'b0;
    #1;
    n_cmp++;
    if ({gnt0, gnt1, mem_en, mem_we} !== 4'b0000) begin
      n_err++; $display("FAIL rstmid_issue: got %b want 0000", {gnt0, gnt1, mem_en, mem_we});
    end
    tick();
    reset = 1'b0;
    n_cmp++;
    if ({rvalid0, rvalid1, err0, err1, rdata} !== 20'h0) begin
      n_err++;
      $display("FAIL rstmid_noresp: got %b/%h want 0000/0000", {rvalid0, rvalid1, err0, err1}, rdata);
    end
    req1 = 1'b1; we1 = 1'b0; addr1 = 9'h014;
    tick();
    n_cmp++;
    if ({gnt0, gnt1} !== 2'b01) begin
      n_err++; $display("FAIL rstmid_solo: got %b want 01", {gnt0, gnt1});
    end
    req1 = 1'b0;
    tick();
    n_cmp++;
    if ({rvalid1, rdata} !== {1'b1, 16'h0352}) begin
      n_err++; $display("FAIL rstmid_solo_data: got %b/%h want 1/0352", rvalid1, rdata);
    end
    req0 = 1'b1; req1 = 1'b1;
    tick();
    n_cmp++;
    if ({gnt0, gnt1} !== 2'b10) begin
      n_err++; $display("FAIL rstmid_both: got %b want 10", {gnt0, gnt1});
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    we0 = 1'b0; addr0 = 9'h005; we1 = 1'b0; addr1 = 9'h014;
    req1 = 1'b1; lock1 = 1'b1;
    tick();
    n_cmp++;
    if ({gnt0, gnt1} !== 2'b01) begin
      n_err++; $display("FAIL lock_first: got %b want 01", {gnt0, gnt1});
    end
    tick();
    req0 = 1'b1; lock1 = 1'b0;
    tick();
    n_cmp++;
    if ({gnt0, gnt1} !== 2'b01) begin
      n_err++; $display("FAIL lock_hold: got %b want 01", {gnt0, gnt1});
    end
    tick();
    tick();
    n_cmp++;
    if ({gnt0, gnt1} !== 2'b10) begin
      n_err++; $display("FAIL lock_release: got %b want 10", {gnt0, gnt1});
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_write_read();
    test_contention();
    test_out_of_range();
    test_reset_mid();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port round-robin arbiter sharing the single-port 256x16 instruction/data RAM between the CPU (port 0) and a debug/program-loader engine (port 1).
- Sits between CPU/loader and the RAM inside the top level.
- Registers each granted request, issues exactly one RAM access, and returns read data with a valid pulse.
- Blocks out-of-range addresses (the I/O space at addr[8]=1) from reaching the RAM.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 9, requester address width (matches CPU PC/address width).
- MEM_AW, 8, RAM address width. Legal addresses are 0 .. 2**MEM_AW-1.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- req0, req1  in  1  request, held until gnt.
- we0, we1  in  1  1=write, 0=read; stable while req high.
- addr0, addr1  in  ADDR_W  request address; stable while req high.
- wdata0, wdata1  in  DATA_W  write data; stable while req high.
- gnt0, gnt1  out  1  one-cycle pulse when the request is issued.
- rvalid0, rvalid1  out  1  one-cycle read-data-valid pulse.
- rdata  out  DATA_W  read data, shared; qualify with rvalidN.
- err0, err1  out  1  one-cycle pulse with rvalidN/ack for an out-of-range access.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write enable.
- mem_addr  out  MEM_AW  RAM address.
- mem_din  out  DATA_W  RAM write data.
- mem_dout  in  DATA_W  RAM read data; synchronous, valid the cycle after mem_en.

Behaviour:
- States: IDLE, ISSUE.
- IDLE:
  - Samples req0/req1 at the clock edge.
  - If any request is high: latch owner, we, addr, wdata, then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle):
  - gnt[owner]=1.
  - mem_en=1 only if the latched addr < 2**MEM_AW; mem_we=latched we; mem_addr=addr[MEM_AW-1:0]; mem_din=latched wdata.
  - Always returns to IDLE. Requests are ignored in ISSUE.
- Response (cycle after ISSUE):
  - Read, in range: rvalid[owner]=1, rdata=mem_dout.
  - Read, out of range: rvalid[owner]=1, rdata=0, err[owner]=1.
  - Write, out of range: err[owner]=1, rvalid stays 0, RAM untouched.
  - Write, in range: no response pulse; gnt is the acknowledgment.
- Latency: req high in cycle T (state IDLE) -> gnt in T+1 -> rvalid/rdata in T+2.
- Throughput: at most one access per 2 cycles.
- Requester must drop req (or present the next request) in the cycle after gnt. A req still high when sampled in IDLE is a new transaction.
- Round-robin:
  - last_owner register, reset value 1, so port 0 wins the first contention.
  - Only one request high: it wins regardless of last_owner.
  - Both high: the port != last_owner wins; last_owner updates on each grant.
  - With continuous contention, grants alternate 0,1,0,1...
- Reset values: state=IDLE, last_owner=1, all gnt/rvalid/err=0, mem_en=0, mem_we=0, mem_addr=0, mem_din=0, rdata=0.
- Reset asserted during ISSUE: the access is aborted and no rvalid/err follows; mem_en/mem_we are 0 from the first reset cycle.
- mem_we is never 1 unless mem_en is 1.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined:
  - Adds inputs lock0, lock1 (1 bit), sampled with the request.
  - If the granted request had lockN=1, only port N is eligible at subsequent IDLE arbitrations, until port N is granted with lockN=0 or reset.
  - Other requests wait, and last_owner does not change while locked.
  - Used for atomic loader bursts.
- Not defined: no lock ports; pure round-robin as above.

Test Plan:
- Read: RAM[0x05]=16'hD401; req0=1, we0=0, addr0=9'h005 in cycle T -> gnt0 in T+1 with mem_en=1, mem_addr=8'h05; rvalid0=1 and rdata=16'hD401 in T+2; gnt1/rvalid1 stay 0.
- Write then read: port1 writes 16'h0352 to 9'h014, then reads 9'h014 -> mem_we=1 only in the write ISSUE cycle; the read returns rvalid1=1, rdata=16'h0352 (850).
- Contention: req0 and req1 held high from reset release through 4 grants -> grant order 0,1,0,1, each gnt two cycles apart, rvalid to the matching port.
- Out of range: req0 read at 9'h100 -> gnt0, mem_en stays 0; next cycle rvalid0=1, err0=1, rdata=0. Write to 9'h140 -> err0=1, no rvalid0, RAM unchanged.
- Reset mid-op: assert reset in the ISSUE cycle of a read -> no rvalid next cycle; all outputs at reset values; after release, req1 alone is granted first; with both high, port 0 is granted first.
- With ARB_LOCK_EN: req1 with lock1=1 granted, req0 and req1 both pending -> port1 granted again; after a port1 grant with lock1=0, port0 is granted next.
